// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: FSM state encoding,
// default boot address and the redirect-target alignment helper.
package fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FC_BOOT  = 2'd0,
    FC_FETCH = 2'd1,
    FC_HOLD  = 2'd2,
    FC_DRAIN = 2'd3
  } fc_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} pair while IF/ID is stalled.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst)        valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // NOTE: the payload is deliberately left unreset; it is only observed while valid=1.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the fetch PC, next-PC selection, the imem
// request/ack handshake, stall buffering and squashing of stale responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush_ifid,
  output logic        flush_idex
);

  fc_state_e   state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc, tgt;
  logic        redir;
  logic        buf_load, buf_clear, buf_valid;
  logic [31:0] buf_pc, buf_instr;

  // EX holds the older instruction, so its redirect takes precedence.
  assign redir     = ex_redirect | id_redirect;
  assign tgt       = align_word(ex_redirect ? ex_target : id_target);
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;

  assign flush_ifid = redir & ~rst;
  assign flush_idex = ex_redirect & ~rst;

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pc    (pc),
    .load_instr (imem_rdata),
    .valid      (buf_valid),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FC_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    if_pc     = 32'd0;
    if_instr  = 32'd0;
    case (state)
      FC_BOOT: begin
        if (redir) pc_nxt = tgt;
        state_nxt = FC_FETCH;
      end
      FC_FETCH: begin
        imem_req = 1'b1;
        if (redir) begin
          pc_nxt = tgt;
          if (!imem_ack) state_nxt = FC_DRAIN;
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (stall) begin
            buf_load  = 1'b1;
            state_nxt = FC_HOLD;
          end else begin
            if_valid = 1'b1;
            if_pc    = pc;
            if_instr = imem_rdata;
          end
        end
      end
      FC_HOLD: begin
        if (redir) begin
          buf_clear = 1'b1;
          pc_nxt    = tgt;
          state_nxt = FC_FETCH;
        end else if (!stall) begin
          if_valid  = buf_valid;
          if_pc     = buf_pc;
          if_instr  = buf_instr;
          buf_clear = 1'b1;
          state_nxt = FC_FETCH;
        end
      end
      FC_DRAIN: begin
        // The response still in flight belongs to the squashed path.
        if (redir)         pc_nxt    = tgt;
        else if (imem_ack) state_nxt = FC_FETCH;
      end
      default: state_nxt = FC_BOOT;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      if_valid = 1'b0;
      if_pc    = 32'd0;
      if_instr = 32'd0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// stall/redirect/latency traffic, all compared against a flag-based fetch model.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush_ifid;
  logic        flush_idex;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: fetch PC plus three mutually exclusive situation flags.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_hold;
  logic [31:0] m_hold_pc;
  logic [31:0] m_hold_instr;
  bit          m_stale;

  // Random-phase memory: one outstanding request with a countdown to its ack.
  bit mem_busy;
  int mem_cnt;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    n_total++;
    assert (obs === req_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, req_v);
  endtask

  function automatic bit model_req();
    return !rst && !m_boot && !m_hold && !m_stale;
  endfunction

  // Checks all outputs for the currently driven inputs, then advances one clock.
  task automatic cycle();
    logic        r;
    logic [31:0] t;
    logic        e_req, e_val;
    logic [31:0] e_pc, e_ins;
    r     = ex_redirect | id_redirect;
    t     = (ex_redirect ? ex_target : id_target) & 32'hFFFF_FFFC;
    e_req = model_req();
    e_val = 1'b0;
    e_pc  = 32'd0;
    e_ins = 32'd0;
    if (!rst && !r && !stall) begin
      if (e_req && imem_ack) begin
        e_val = 1'b1; e_pc = m_pc; e_ins = imem_rdata;
      end else if (m_hold) begin
        e_val = 1'b1; e_pc = m_hold_pc; e_ins = m_hold_instr;
      end
    end
    @(negedge clk);
    check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (!rst) check("imem_addr", imem_addr, m_pc);
    check("flush_ifid", {31'd0, flush_ifid}, {31'd0, !rst && r});
    check("flush_idex", {31'd0, flush_idex}, {31'd0, !rst && ex_redirect});
    check("if_valid", {31'd0, if_valid}, {31'd0, e_val});
    check("if_pc", if_pc, e_pc);
    check("if_instr", if_instr, e_ins);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'd0; m_boot = 1; m_hold = 0; m_stale = 0;
    end else if (m_boot) begin
      if (r) m_pc = t;
      m_boot = 0;
    end else if (m_hold) begin
      if (r) m_pc = t;
      if (r || !stall) m_hold = 0;
    end else if (m_stale) begin
      if (r) m_pc = t;
      else if (imem_ack) m_stale = 0;
    end else if (r) begin
      m_pc = t;
      if (!imem_ack) m_stale = 1;
    end else if (imem_ack) begin
      if (stall) begin
        m_hold = 1; m_hold_pc = m_pc; m_hold_instr = imem_rdata;
      end
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic step(input logic r_i, input logic st_i, input logic idr_i,
                      input logic [31:0] idt_i, input logic exr_i,
                      input logic [31:0] ext_i, input logic ack_i,
                      input logic [31:0] rd_i);
    rst = r_i; stall = st_i; id_redirect = idr_i; id_target = idt_i;
    ex_redirect = exr_i; ex_target = ext_i; imem_ack = ack_i; imem_rdata = rd_i;
    cycle();
  endtask

  initial begin
    m_pc = 32'd0; m_boot = 1; m_hold = 0; m_stale = 0;
    m_hold_pc = 32'd0; m_hold_instr = 32'd0;
    mem_busy = 0; mem_cnt = 0;

    // Reset with redirects asserted: flushes must stay low.
    step(1, 0, 1, 32'h55, 1, 32'h66, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Boot cycle, then zero-wait fetches 0,4,8,C.
    step(0, 0, 0, 0, 0, 0, 1, 32'h1111_0000);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom);
    check("zero_wait_addr", imem_addr, 32'h10);

    // Ack delayed three cycles at 0x10.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 1, 32'hABCD_0010);
    check("delayed_next_addr", imem_addr, 32'h14);

    // Stall while the 0x20 response arrives, then release.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom);
    step(0, 1, 0, 0, 0, 0, 1, 32'hCAFE_0020);
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 1, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    check("hold_next_addr", imem_addr, 32'h24);

    // EX redirect while 0x40 is pending; its response is dropped.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 1, 32'h103, 0, $urandom);
    check("drain_target", imem_addr, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0040);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);

    // ID and EX redirect together with a stall: EX wins.
    step(0, 1, 1, 32'h200, 1, 32'h300, 1, $urandom);
    check("ex_over_id", imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, $urandom);
    check("wrap_start", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 1, 32'h5A5A_FFFC);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset while holding a buffered instruction.
    step(0, 1, 0, 0, 0, 0, 1, 32'h7777_0000);
    step(1, 1, 0, 0, 0, 0, 0, $urandom);
    check("rst_hold_pc", imem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, $urandom);

    // Random traffic with variable memory latency.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        mem_busy = 0;
        imem_ack = 1'b0;
      end else begin
        if (!mem_busy && model_req()) begin
          mem_busy = 1;
          mem_cnt  = $urandom_range(0, 3);
        end
        if (mem_busy && mem_cnt == 0) begin
          imem_ack = 1'b1;
          mem_busy = 0;
        end else begin
          imem_ack = 1'b0;
          if (mem_busy) mem_cnt--;
        end
      end
      imem_rdata  = $urandom;
      stall       = ($urandom_range(0, 9) < 3);
      id_redirect = ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      id_target   = $urandom;
      ex_target   = $urandom;
      // A redirect coinciding with the stale ack would leave no response to wait for.
      if (m_stale && imem_ack) begin
        id_redirect = 1'b0;
        ex_redirect = 1'b0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
